// File: rtl/soc_bus_pkg.sv
// Shared types and constants for the SoC bus fabric and its address decoder.
// The wait/timeout counter width also bounds the ack-mode TIMEOUT (max 255).
package soc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_ACK_MODE = 4'hF;
  localparam int         CNT_W         = 8;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/bus_decoder.sv
// Address region decoder: slave i hits when (addr & mask[i]) == base[i].
// Purely combinational; on overlapping regions the lowest index wins.
module bus_decoder
  import soc_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int N_SLAVES   = 4,
  parameter int IDX_W      = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [N_SLAVES*ADDR_WIDTH-1:0] base,
  input  logic [N_SLAVES*ADDR_WIDTH-1:0] mask,
  output logic [N_SLAVES-1:0]            hit_vec,
  output logic                           hit,
  output logic [IDX_W-1:0]               hit_idx
);

  // Scan from the top down so the lowest matching index is written last.
  always_comb begin
    hit_vec = '0;
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((addr & mask[i*ADDR_WIDTH +: ADDR_WIDTH]) == base[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit_vec    = '0;
        hit_vec[i] = 1'b1;
        hit        = 1'b1;
        hit_idx    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/soc_bus_fabric.sv
// CPU-to-slave bus fabric: decode, register the slave-side request, count wait
// states or wait for ack (with timeout), then pulse m_ready for one response cycle.
module soc_bus_fabric
  import soc_bus_pkg::*;
#(
  parameter int                              ADDR_WIDTH = 20,
  parameter int                              DATA_WIDTH = 16,
  parameter int                              N_SLAVES   = 4,
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0]  BASE       = '0,
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0]  MASK       = '0,
  parameter logic [N_SLAVES*4-1:0]           WAIT       = '0,
  parameter int                              TIMEOUT    = 15
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          m_addr,
  input  logic [DATA_WIDTH-1:0]          m_wdata,
  input  logic                           m_read,
  input  logic                           m_write,
  output logic [DATA_WIDTH-1:0]          m_rdata,
  output logic                           m_ready,
  output logic                           m_error,
  output logic [N_SLAVES-1:0]            s_sel,
  output logic [ADDR_WIDTH-1:0]          s_addr,
  output logic [DATA_WIDTH-1:0]          s_wdata,
  output logic                           s_read,
  output logic                           s_write,
  input  logic [N_SLAVES*DATA_WIDTH-1:0] s_rdata,
  input  logic [N_SLAVES-1:0]            s_ack
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  state_t                state_q, state_d;
  cnt_t                  cnt_q, cnt_d;
  logic [N_SLAVES-1:0]   sel_q, sel_d;
  logic                  rd_q, rd_d, wr_q, wr_d;
  logic                  ack_mode_q, ack_mode_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [N_SLAVES-1:0]   hit_vec;
  logic                  hit;
  logic [IDX_W-1:0]      hit_idx;
  logic [3:0]            hit_wait;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  sel_ack;
  logic                  done;
  logic                  ok;

  bus_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .N_SLAVES   (N_SLAVES),
    .IDX_W      (IDX_W)
  ) u_dec (
    .addr    (m_addr),
    .base    (BASE),
    .mask    (MASK),
    .hit_vec (hit_vec),
    .hit     (hit),
    .hit_idx (hit_idx)
  );

  // Wait count of the decoded slave, and data/ack of the slave currently selected.
  always_comb begin
    hit_wait  = '0;
    sel_rdata = '0;
    sel_ack   = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (hit_idx == IDX_W'(i)) hit_wait = WAIT[i*4 +: 4];
      if (sel_q[i]) begin
        sel_rdata = sel_rdata | s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_ack   = sel_ack | s_ack[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    ack_mode_d = ack_mode_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    done       = 1'b0;
    ok         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if ((m_read ^ m_write) && hit) begin
          addr_d     = m_addr;
          wdata_d    = m_wdata;
          sel_d      = hit_vec;
          rd_d       = m_read;
          wr_d       = m_write;
          ack_mode_d = (hit_wait == WAIT_ACK_MODE);
          cnt_d      = (hit_wait == WAIT_ACK_MODE) ? cnt_t'(TIMEOUT) : {4'b0000, hit_wait};
          err_d      = 1'b0;
          state_d    = ACCESS;
        end else if (m_read || m_write) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end
      end

      ACCESS: begin
        // Ack is checked before the counter so a last-cycle ack still succeeds.
        if (ack_mode_q) begin
          if (sel_ack) begin
            done = 1'b1;
            ok   = 1'b1;
          end else if (cnt_q == '0) begin
            done = 1'b1;
          end
        end else if (cnt_q == '0) begin
          done = 1'b1;
          ok   = 1'b1;
        end

        if (done) begin
          state_d = RESP;
          sel_d   = '0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = !ok;
          if (!ok)       rdata_d = '0;
          else if (rd_q) rdata_d = sel_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RESP: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      ack_mode_q <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      ack_mode_q <= ack_mode_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  assign m_ready = (state_q == RESP);
  assign m_error = m_ready & err_q;
  assign m_rdata = rdata_q;
  assign s_sel   = sel_q;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;
  assign s_read  = rd_q;
  assign s_write = wr_q;

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Scoreboard bench for soc_bus_fabric: a driver queues the expected response of
// each transfer, a negedge monitor checks every m_ready pulse against it.
module tb_soc_bus_fabric;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int NS = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [AW-1:0]  m_addr;
  logic [DW-1:0]  m_wdata;
  logic           m_read;
  logic           m_write;
  logic [DW-1:0]  m_rdata;
  logic           m_ready;
  logic           m_error;
  logic [NS-1:0]  s_sel;
  logic [AW-1:0]  s_addr;
  logic [DW-1:0]  s_wdata;
  logic           s_read;
  logic           s_write;
  logic [NS*DW-1:0] s_rdata;
  logic [NS-1:0]  s_ack;

  logic [DW-1:0]  mem0 [0:63];
  logic [DW-1:0]  s1_data;
  logic [DW-1:0]  s2_data;

  soc_bus_fabric #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .N_SLAVES   (NS),
    .BASE       ({20'h90000, 20'h80000, 20'h00000}),
    .MASK       ({20'hFFFF0, 20'hFFFF0, 20'hFFC00}),
    .WAIT       ({4'hF, 4'h2, 4'h0}),
    .TIMEOUT    (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_read  (m_read),
    .m_write (m_write),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .m_error (m_error),
    .s_sel   (s_sel),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_read  (s_read),
    .s_write (s_write),
    .s_rdata (s_rdata),
    .s_ack   (s_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave 0: small RAM; slaves 1 and 2: bench-driven read data.
  always @(posedge clk) begin
    if (s_write && s_sel[0]) mem0[s_addr[5:0]] <= s_wdata;
  end
  assign s_rdata = {s2_data, s1_data, mem0[s_addr[5:0]]};

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            k;
    int            lat;
    int            nrd;
    int            nwr;
    logic [NS-1:0] sel;
  } exp_t;

  exp_t          exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] model_rdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: tally strobes per transfer and check each response.
  int            mon_nrd = 0;
  int            mon_nwr = 0;
  logic [NS-1:0] mon_sel = '0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      mon_nrd = 0;
      mon_nwr = 0;
      mon_sel = '0;
    end else begin
      if (s_read)  mon_nrd++;
      if (s_write) mon_nwr++;
      if (s_read || s_write) mon_sel = mon_sel | s_sel;
      if (m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_m_ready", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("m_rdata",  32'(m_rdata), 32'(e.rdata));
          chk("m_error",  32'(m_error), 32'(e.err));
          chk("latency",  32'(cyc - e.k + 1), 32'(e.lat));
          chk("n_read",   32'(mon_nrd), 32'(e.nrd));
          chk("n_write",  32'(mon_nwr), 32'(e.nwr));
          chk("sel",      32'(mon_sel), 32'(e.sel));
          chk("resp_quiet", {29'd0, s_sel}, 32'd0);
        end
        mon_nrd = 0;
        mon_nwr = 0;
        mon_sel = '0;
      end
    end
  end

  // One transfer; ack_dly >= 0 pulses slave 2 ack after that many strobe cycles.
  task automatic xfer(input logic rd, input logic wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input logic [DW-1:0] rdv, input logic err,
                      input int lat, input int nrd, input int nwr,
                      input logic [NS-1:0] sel, input int ack_dly);
    exp_t e;
    int   nstb;
    bit   seen;
    @(negedge clk);
    e.rdata     = err ? '0 : ((rd && !wr) ? rdv : model_rdata);
    model_rdata = e.rdata;
    e.err = err;
    e.k   = cyc + 1;
    e.lat = lat;
    e.nrd = nrd;
    e.nwr = nwr;
    e.sel = sel;
    exp_q.push_back(e);
    m_addr  = addr;
    m_wdata = wd;
    m_read  = rd;
    m_write = wr;
    nstb = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_ready) begin
        seen = 1;
        break;
      end
      if (s_read || s_write) nstb++;
      s_ack = (ack_dly >= 0 && nstb == ack_dly + 1) ? 3'b100 : 3'b000;
    end
    m_read  = 1'b0;
    m_write = 1'b0;
    s_ack   = '0;
    if (!seen) chk("xfer_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset   = 1'b1;
    m_addr  = '0;
    m_wdata = '0;
    m_read  = 1'b0;
    m_write = 1'b0;
    s_ack   = '0;
    s1_data = 16'hBEEF;
    s2_data = 16'h00A5;
    for (int i = 0; i < 64; i++) mem0[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_m_ready", 32'(m_ready), 32'd0);
    chk("rst_m_rdata", 32'(m_rdata), 32'd0);
    chk("rst_s_read",  32'(s_read),  32'd0);
    chk("rst_s_sel",   32'(s_sel),   32'd0);
    reset = 1'b0;

    //   rd    wr    addr       wdata     rdv       err   lat nrd nwr sel     ack
    xfer(1'b0, 1'b1, 20'h00010, 16'h1234, 16'h0000, 1'b0, 2,  0,  1,  3'b001, -1);
    xfer(1'b1, 1'b0, 20'h00010, 16'h0000, 16'h1234, 1'b0, 2,  1,  0,  3'b001, -1);
    xfer(1'b1, 1'b0, 20'h80004, 16'h0000, 16'hBEEF, 1'b0, 4,  3,  0,  3'b010, -1);
    xfer(1'b0, 1'b1, 20'h80008, 16'h5555, 16'h0000, 1'b0, 4,  0,  3,  3'b010, -1);
    xfer(1'b1, 1'b0, 20'h90000, 16'h0000, 16'h00A5, 1'b0, 7,  6,  0,  3'b100,  5);
    xfer(1'b1, 1'b0, 20'h90000, 16'h0000, 16'h00A5, 1'b1, 10, 9,  0,  3'b100, -1);
    xfer(1'b1, 1'b0, 20'h00010, 16'h0000, 16'h1234, 1'b0, 2,  1,  0,  3'b001, -1);
    xfer(1'b1, 1'b0, 20'h40000, 16'h0000, 16'h0000, 1'b1, 1,  0,  0,  3'b000, -1);
    xfer(1'b1, 1'b0, 20'h00010, 16'h0000, 16'h1234, 1'b0, 2,  1,  0,  3'b001, -1);
    xfer(1'b1, 1'b1, 20'h00010, 16'h7777, 16'h0000, 1'b1, 1,  0,  0,  3'b000, -1);

    // Reset in the middle of a slave 1 wait sequence aborts without a response.
    @(negedge clk);
    m_addr = 20'h80004;
    m_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_s_read", 32'(s_read), 32'd1);
    reset  = 1'b1;
    m_read = 1'b0;
    @(negedge clk);
    chk("abort_s_read",  32'(s_read),  32'd0);
    chk("abort_s_sel",   32'(s_sel),   32'd0);
    chk("abort_m_ready", 32'(m_ready), 32'd0);
    chk("abort_m_rdata", 32'(m_rdata), 32'd0);
    chk("abort_s_addr",  32'(s_addr),  32'd0);
    reset       = 1'b0;
    model_rdata = '0;
    repeat (8) @(negedge clk);

    xfer(1'b1, 1'b0, 20'h00010, 16'h0000, 16'h1234, 1'b0, 2,  1,  0,  3'b001, -1);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
